// File: rtl/uart_pkg.sv
// Shared encodings for the UART frame engine: parity modes, data lengths
// and the FSM states used by both the TX and RX machines.
// Optional parity support is compiled in with the UART_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_e;

    typedef enum logic [1:0] {
        DLEN_5 = 2'b00,
        DLEN_6 = 2'b01,
        DLEN_7 = 2'b10,
        DLEN_8 = 2'b11
    } data_len_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } frame_state_e;

    // Index of the last data bit for a given length code (5 bits -> 4 ... 8 bits -> 7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
        return 3'd4 + {1'b0, len};
    endfunction

    // Mask selecting the data bits that are actually transmitted.
    function automatic logic [7:0] len_mask(input logic [1:0] len);
        logic [7:0] m;
        case (data_len_e'(len))
            DLEN_5:  m = 8'h1F;
            DLEN_6:  m = 8'h3F;
            DLEN_7:  m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // True when the mode code selects a parity bit.
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit to transmit: XOR of the live data bits, inverted for odd mode.
    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] len,
                                       input logic [1:0] mode);
        return (^(data & len_mask(len))) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud divider: counts 0..timer_final_value and raises s_tick
// for the single clock in which the count sits at its terminal value.
module uart_baud_tick #(
    parameter int DIVW = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DIVW-1:0] timer_final_value,
    output logic            s_tick
);

    logic [DIVW-1:0] cnt;

    // Wrap at the terminal count; the >= guards against the terminal being lowered below cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt >= timer_final_value) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIVW'(1);
        end
    end

    assign s_tick = (cnt == timer_final_value);

endmodule

// File: rtl/uart_frame_engine.sv
// UART frame engine: configurable TX and RX framers sharing one oversampling
// baud tick. Data length 5..8, optional parity (UART_PARITY_EN), 1 or 2 TX stop bits.
// Without UART_PARITY_EN the parity states vanish and rx_parity_err is tied low.
module uart_frame_engine
    import uart_pkg::*;
#(
    parameter int DIVW    = 11,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DIVW-1:0] timer_final_value,
    input  logic [1:0]      cfg_data_bits,
    input  logic [1:0]      cfg_parity,
    input  logic            cfg_stop2,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            tx,
    input  logic            rx,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            rx_parity_err,
    output logic            rx_frame_err,
    output logic            rx_overrun
);

    localparam int TCW = $clog2(2 * SB_TICK);
    localparam logic [TCW-1:0] TICK_HALF  = TCW'(SB_TICK / 2 - 1);
    localparam logic [TCW-1:0] TICK_BIT   = TCW'(SB_TICK - 1);
    localparam logic [TCW-1:0] TICK_STOP2 = TCW'(2 * SB_TICK - 1);

    logic s_tick;

    uart_baud_tick #(.DIVW(DIVW)) u_baud (
        .clk               (clk),
        .reset             (reset),
        .timer_final_value (timer_final_value),
        .s_tick            (s_tick)
    );

    // ---------------- TX ----------------
    frame_state_e   tx_state, tx_state_n;
    logic [TCW-1:0] tx_tick, tx_tick_n;
    logic [2:0]     tx_bit, tx_bit_n;
    logic [2:0]     tx_last, tx_last_n;
    logic [7:0]     tx_shreg, tx_shreg_n;
    logic           tx_stop2, tx_stop2_n;
    logic           tx_q, tx_q_n;
`ifdef UART_PARITY_EN
    logic           tx_par_en, tx_par_en_n;
    logic           tx_par_bit, tx_par_bit_n;
`endif

    // TX next-state logic; tx_q_n is the line level for the state being entered.
    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_last_n  = tx_last;
        tx_shreg_n = tx_shreg;
        tx_stop2_n = tx_stop2;
`ifdef UART_PARITY_EN
        tx_par_en_n  = tx_par_en;
        tx_par_bit_n = tx_par_bit;
`endif
        case (tx_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    tx_state_n = ST_START;
                    tx_tick_n  = '0;
                    tx_shreg_n = tx_data;
                    tx_last_n  = last_bit_idx(cfg_data_bits);
                    tx_stop2_n = cfg_stop2;
`ifdef UART_PARITY_EN
                    tx_par_en_n  = parity_on(cfg_parity);
                    tx_par_bit_n = parity_of(tx_data, cfg_data_bits, cfg_parity);
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tx_tick == TICK_BIT) begin
                        tx_tick_n  = '0;
                        tx_bit_n   = '0;
                        tx_state_n = ST_DATA;
                    end else begin
                        tx_tick_n = tx_tick + TCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tx_tick == TICK_BIT) begin
                        tx_tick_n  = '0;
                        tx_shreg_n = tx_shreg >> 1;
                        if (tx_bit == tx_last) begin
`ifdef UART_PARITY_EN
                            tx_state_n = tx_par_en ? ST_PARITY : ST_STOP;
`else
                            tx_state_n = ST_STOP;
`endif
                        end else begin
                            tx_bit_n = tx_bit + 3'd1;
                        end
                    end else begin
                        tx_tick_n = tx_tick + TCW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (tx_tick == TICK_BIT) begin
                        tx_tick_n  = '0;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_tick_n = tx_tick + TCW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (tx_tick == (tx_stop2 ? TICK_STOP2 : TICK_BIT)) begin
                        tx_tick_n  = '0;
                        tx_state_n = ST_IDLE;
                    end else begin
                        tx_tick_n = tx_tick + TCW'(1);
                    end
                end
            end
            default: begin
                tx_tick_n  = '0;
                tx_state_n = ST_IDLE;
            end
        endcase

        tx_q_n = 1'b1;
        case (tx_state_n)
            ST_START:  tx_q_n = 1'b0;
            ST_DATA:   tx_q_n = tx_shreg_n[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_q_n = tx_par_bit_n;
`endif
            default:   tx_q_n = 1'b1;
        endcase
    end

    // TX control registers; the serial line is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_q     <= tx_q_n;
        end
    end

    // TX frame snapshot: data and configuration held for the whole frame.
    always_ff @(posedge clk) begin
        tx_shreg <= tx_shreg_n;
        tx_last  <= tx_last_n;
        tx_stop2 <= tx_stop2_n;
`ifdef UART_PARITY_EN
        tx_par_en  <= tx_par_en_n;
        tx_par_bit <= tx_par_bit_n;
`endif
    end

    assign tx       = tx_q;
    assign tx_ready = (tx_state == ST_IDLE);

    // ---------------- RX ----------------
    logic           rx_s1, rx_s2;
    logic           rx_armed, rx_armed_n;
    frame_state_e   rx_state, rx_state_n;
    logic [TCW-1:0] rx_tick, rx_tick_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [2:0]     rx_last, rx_last_n;
    logic [7:0]     rx_buf, rx_buf_n;
    logic           rx_done, rx_stop_bad;
    logic           rx_handshake;
`ifdef UART_PARITY_EN
    logic           rx_par_en, rx_par_en_n;
    logic           rx_par_odd, rx_par_odd_n;
    logic           rx_par_fail, rx_par_fail_n;
    logic           rx_parity_err_q;
`else
    logic           unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_parity;
`endif

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // RX next-state logic: start detect, mid-start resample, then one sample per bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_tick_n   = rx_tick;
        rx_bit_n    = rx_bit;
        rx_last_n   = rx_last;
        rx_buf_n    = rx_buf;
        rx_armed_n  = rx_armed;
        rx_done     = 1'b0;
        rx_stop_bad = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_en_n   = rx_par_en;
        rx_par_odd_n  = rx_par_odd;
        rx_par_fail_n = rx_par_fail;
`endif
        case (rx_state)
            ST_IDLE: begin
                // A line that has never been seen high (e.g. a held break) cannot start a frame.
                if (!rx_armed) begin
                    rx_armed_n = rx_s2;
                end else if (!rx_s2) begin
                    rx_armed_n = 1'b0;
                    rx_state_n = ST_START;
                    rx_tick_n  = '0;
                    rx_buf_n   = '0;
                    rx_last_n  = last_bit_idx(cfg_data_bits);
`ifdef UART_PARITY_EN
                    rx_par_en_n   = parity_on(cfg_parity);
                    rx_par_odd_n  = (cfg_parity == PAR_ODD);
                    rx_par_fail_n = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (rx_tick == TICK_HALF) begin
                        rx_tick_n = '0;
                        rx_bit_n  = '0;
                        rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_tick_n = rx_tick + TCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (rx_tick == TICK_BIT) begin
                        rx_tick_n        = '0;
                        rx_buf_n[rx_bit] = rx_s2;
                        if (rx_bit == rx_last) begin
`ifdef UART_PARITY_EN
                            rx_state_n = rx_par_en ? ST_PARITY : ST_STOP;
`else
                            rx_state_n = ST_STOP;
`endif
                        end else begin
                            rx_bit_n = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_tick_n = rx_tick + TCW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (rx_tick == TICK_BIT) begin
                        rx_tick_n     = '0;
                        rx_par_fail_n = rx_s2 ^ (^rx_buf) ^ rx_par_odd;
                        rx_state_n    = ST_STOP;
                    end else begin
                        rx_tick_n = rx_tick + TCW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (rx_tick == TICK_BIT) begin
                        rx_tick_n   = '0;
                        rx_done     = 1'b1;
                        rx_stop_bad = !rx_s2;
                        rx_state_n  = ST_IDLE;
                    end else begin
                        rx_tick_n = rx_tick + TCW'(1);
                    end
                end
            end
            default: begin
                rx_tick_n  = '0;
                rx_state_n = ST_IDLE;
            end
        endcase
    end

    // RX control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= ST_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_armed <= rx_armed_n;
        end
    end

    // RX frame assembly registers.
    always_ff @(posedge clk) begin
        rx_buf  <= rx_buf_n;
        rx_last <= rx_last_n;
`ifdef UART_PARITY_EN
        rx_par_en   <= rx_par_en_n;
        rx_par_odd  <= rx_par_odd_n;
        rx_par_fail <= rx_par_fail_n;
`endif
    end

    assign rx_handshake = rx_valid && rx_ready;

    // Output holding register: a completed frame is dropped (and flagged) only if the
    // previous one is still pending and not being taken in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            if (rx_handshake) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (rx_done) begin
                if (!rx_valid || rx_handshake) begin
                    rx_valid     <= 1'b1;
                    rx_data      <= rx_buf;
                    rx_frame_err <= rx_stop_bad;
`ifdef UART_PARITY_EN
                    rx_parity_err_q <= rx_par_fail;
`endif
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_engine.sv
// Self-checking bench for uart_frame_engine: tx looped to rx (or driven directly
// for error injection), timer_final_value=3, SB_TICK=16, 64 clocks per bit.
module tb_uart_frame_engine;

    localparam int DIVW    = 11;
    localparam int SB_TICK = 16;
    localparam int TFV     = 3;
    localparam int BITCLK  = (TFV + 1) * SB_TICK;
`ifdef UART_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DIVW-1:0] timer_final_value = DIVW'(TFV);
    logic [1:0]      cfg_data_bits = 2'b11;
    logic [1:0]      cfg_parity = 2'b00;
    logic            cfg_stop2 = 1'b0;
    logic [7:0]      tx_data = 8'h00;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic            tx;
    logic            rx_line;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready = 1'b0;
    logic            rx_parity_err, rx_frame_err, rx_overrun;

    logic loopback = 1'b1;
    logic rx_drv = 1'b1;
    assign rx_line = loopback ? tx : rx_drv;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cyc_rst = 0;

    uart_frame_engine #(.DIVW(DIVW), .SB_TICK(SB_TICK)) dut (
        .clk               (clk),
        .reset             (reset),
        .timer_final_value (timer_final_value),
        .cfg_data_bits     (cfg_data_bits),
        .cfg_parity        (cfg_parity),
        .cfg_stop2         (cfg_stop2),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx                (tx),
        .rx                (rx_line),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .rx_parity_err     (rx_parity_err),
        .rx_frame_err      (rx_frame_err),
        .rx_overrun        (rx_overrun)
    );

    always #5 clk = ~clk;

    // Edge counter; cyc_rst marks the last edge that saw reset, after which the baud count is 0.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) cyc_rst = cyc;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model ----
    function automatic bit par_active(input logic [1:0] par);
        return PAR_BUILD && (par == 2'b01 || par == 2'b10);
    endfunction

    function automatic int frame_len(input logic [1:0] db, input logic [1:0] par, input logic st2);
        return 1 + (5 + int'(db)) + (par_active(par) ? 1 : 0) + 1 + (st2 ? 1 : 0);
    endfunction

    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [1:0] db,
                                               input logic [1:0] par, input logic st2);
        logic [11:0] b;
        int n, k;
        logic p;
        b = '0;
        n = 5 + int'(db);
        k = 1;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            b[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (par_active(par)) begin
            b[k] = (par == 2'b10) ? ~p : p;
            k++;
        end
        b[k] = 1'b1;
        k++;
        if (st2) b[k] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] data_mask(input logic [7:0] d, input logic [1:0] db);
        return d & 8'((1 << (5 + int'(db))) - 1);
    endfunction

    // ---- stimulus helpers (no checking inside) ----
    // Send one TX frame, accepted on the edge that ends a baud-tick cycle so bits start on
    // 64-clock boundaries; samples tx mid-bit and counts cycles with tx_ready low.
    task automatic xmit(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                        input logic st2, input bit scramble,
                        output int low, output logic [11:0] samp);
        int c;
        samp = '0;
        low  = 0;
        tx_data = d;
        cfg_data_bits = db;
        cfg_parity = par;
        cfg_stop2 = st2;
        while (((cyc - cyc_rst) % (TFV + 1)) != TFV) tick1();
        tx_valid = 1'b1;
        tick1();
        tx_valid = 1'b0;
        c = 0;
        while (tx_ready == 1'b0 && c < 1200) begin
            if ((c % BITCLK) == BITCLK / 2 && (c / BITCLK) < 12) samp[c / BITCLK] = tx;
            if (scramble && c == 100) begin
                tx_data = 8'($urandom);
                cfg_data_bits = 2'($urandom);
                cfg_parity = 2'($urandom);
                cfg_stop2 = 1'($urandom);
            end
            low++;
            tick1();
            c++;
        end
    endtask

    task automatic wait_rx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            tick1();
        end
    endtask

    task automatic take_rx();
        rx_ready = 1'b1;
        tick1();
        rx_ready = 1'b0;
    endtask

    task automatic drive_bits(input logic [11:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            rx_drv = b[k];
            repeat (BITCLK) tick1();
        end
    endtask

    task automatic watch_no_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_valid) seen++;
            tick1();
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1;
        repeat (5) tick1();
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {rx_parity_err, rx_frame_err, rx_overrun});
        end
        reset = 1'b0;
        repeat (3) tick1();
    endtask

    task automatic test_8n1();
        int low; logic [11:0] samp; bit ok;
        loopback = 1'b1;
        xmit(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, low, samp);
        checks++; if (low !== 640) begin failures++; $display("FAIL 8n1_ready_low got=%0d exp=640", low); end
        checks++; if (samp !== frame_bits(8'hA5, 2'b11, 2'b00, 1'b0)) begin
            failures++; $display("FAIL 8n1_tx_bits got=%b exp=%b", samp, frame_bits(8'hA5, 2'b11, 2'b00, 1'b0));
        end
        wait_rx(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL 8n1_rx_valid got=0 exp=1"); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL 8n1_rx_data got=%h exp=a5", rx_data); end
        checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin
            failures++; $display("FAIL 8n1_flags got=%b exp=000", {rx_parity_err, rx_frame_err, rx_overrun});
        end
        take_rx();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL 8n1_handshake got=%b exp=0", rx_valid); end
    endtask

    task automatic test_parity();
        int low; logic [11:0] samp; logic [11:0] bad; bit ok;
        loopback = 1'b1;
        xmit(8'h35, 2'b10, 2'b01, 1'b0, 1'b0, low, samp);
        checks++; if (low !== 64 * frame_len(2'b10, 2'b01, 1'b0)) begin
            failures++; $display("FAIL 7e1_ready_low got=%0d exp=%0d", low, 64 * frame_len(2'b10, 2'b01, 1'b0));
        end
        checks++; if (samp !== frame_bits(8'h35, 2'b10, 2'b01, 1'b0)) begin
            failures++; $display("FAIL 7e1_tx_bits got=%b exp=%b", samp, frame_bits(8'h35, 2'b10, 2'b01, 1'b0));
        end
`ifdef UART_PARITY_EN
        checks++; if (samp[8] !== 1'b0) begin failures++; $display("FAIL 7e1_parity_bit got=%b exp=0", samp[8]); end
`endif
        wait_rx(200, ok);
        checks++; if (!ok || rx_data !== 8'h35) begin failures++; $display("FAIL 7e1_rx_data got=%h exp=35", rx_data); end
        checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL 7e1_parity_err got=%b exp=0", rx_parity_err); end
        take_rx();
`ifdef UART_PARITY_EN
        xmit(8'h35, 2'b10, 2'b10, 1'b0, 1'b0, low, samp);
        checks++; if (samp[8] !== 1'b1) begin failures++; $display("FAIL 7o1_parity_bit got=%b exp=1", samp[8]); end
        wait_rx(200, ok);
        checks++; if (!ok || rx_data !== 8'h35 || rx_parity_err !== 1'b0) begin
            failures++; $display("FAIL 7o1_rx got=%h/%b exp=35/0", rx_data, rx_parity_err);
        end
        take_rx();
`endif
        // Even-parity frame with the parity bit flipped, driven straight onto rx.
        loopback = 1'b0;
        rx_drv = 1'b1;
        cfg_data_bits = 2'b10;
        cfg_parity = 2'b01;
        cfg_stop2 = 1'b0;
        repeat (BITCLK) tick1();
        bad = frame_bits(8'h35, 2'b10, 2'b01, 1'b0);
        if (PAR_BUILD) bad[8] = ~bad[8];
        drive_bits(bad, frame_len(2'b10, 2'b01, 1'b0));
        rx_drv = 1'b1;
        wait_rx(200, ok);
        checks++; if (!ok || rx_data !== 8'h35) begin failures++; $display("FAIL inj_par_rx_data got=%h exp=35", rx_data); end
        checks++; if (rx_parity_err !== PAR_BUILD) begin
            failures++; $display("FAIL inj_parity_err got=%b exp=%b", rx_parity_err, PAR_BUILD);
        end
        take_rx();
        loopback = 1'b1;
    endtask

    task automatic test_frame_err();
        logic [11:0] b; bit ok; int seen;
        loopback = 1'b0;
        rx_drv = 1'b1;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        repeat (BITCLK) tick1();
        b = frame_bits(8'hC3, 2'b11, 2'b00, 1'b0);
        b[9] = 1'b0;
        drive_bits(b, 10);
        rx_drv = 1'b0;
        wait_rx(200, ok);
        checks++; if (!ok || rx_frame_err !== 1'b1) begin failures++; $display("FAIL stop_low_frame_err got=%b exp=1", rx_frame_err); end
        checks++; if (rx_data !== 8'hC3) begin failures++; $display("FAIL stop_low_rx_data got=%h exp=c3", rx_data); end
        take_rx();
        watch_no_valid(12 * BITCLK, seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL held_low_restart got=%0d exp=0", seen); end
        rx_drv = 1'b1;
        repeat (2 * BITCLK) tick1();
        drive_bits(frame_bits(8'h5A, 2'b11, 2'b00, 1'b0), 10);
        rx_drv = 1'b1;
        wait_rx(200, ok);
        checks++; if (!ok || rx_data !== 8'h5A || rx_frame_err !== 1'b0) begin
            failures++; $display("FAIL recover_rx got=%h/%b exp=5a/0", rx_data, rx_frame_err);
        end
        take_rx();
        loopback = 1'b1;
    endtask

    task automatic test_overrun();
        int low; logic [11:0] samp;
        loopback = 1'b1;
        rx_ready = 1'b0;
        xmit(8'h11, 2'b11, 2'b00, 1'b0, 1'b0, low, samp);
        xmit(8'h22, 2'b11, 2'b00, 1'b0, 1'b0, low, samp);
        repeat (BITCLK) tick1();
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            failures++; $display("FAIL overrun_keeps_old got=%b/%h exp=1/11", rx_valid, rx_data);
        end
        checks++; if (rx_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", rx_overrun); end
        take_rx();
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
            failures++; $display("FAIL overrun_clear got=%b/%b exp=0/0", rx_valid, rx_overrun);
        end
    endtask

    task automatic test_glitch();
        int seen;
        loopback = 1'b0;
        rx_drv = 1'b1;
        repeat (BITCLK) tick1();
        rx_drv = 1'b0;
        repeat (16) tick1();
        rx_drv = 1'b1;
        watch_no_valid(12 * BITCLK, seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL glitch_rejected got=%0d exp=0", seen); end
        loopback = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        loopback = 1'b1;
        tx_data = 8'h96;
        cfg_data_bits = 2'b11;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        while (((cyc - cyc_rst) % (TFV + 1)) != TFV) tick1();
        tx_valid = 1'b1;
        tick1();
        tx_valid = 1'b0;
        repeat (3 * BITCLK + 20) tick1();
        reset = 1'b1;
        tick1();
        checks++; if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            failures++; $display("FAIL reset_mid_tx got=%b/%b exp=1/1", tx, tx_ready);
        end
        reset = 1'b0;
        watch_no_valid(15 * BITCLK, seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_rx got=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        int low; logic [11:0] samp; bit ok;
        logic [7:0] d; logic [1:0] db, par; logic st2;
        loopback = 1'b1;
        for (int it = 0; it < 8; it++) begin
            d = 8'($urandom);
            db = 2'($urandom);
            par = 2'($urandom);
            st2 = 1'($urandom);
            xmit(d, db, par, st2, (it % 2) == 1, low, samp);
            checks++; if (low !== 64 * frame_len(db, par, st2)) begin
                failures++; $display("FAIL rnd%0d_ready_low got=%0d exp=%0d", it, low, 64 * frame_len(db, par, st2));
            end
            checks++; if (samp !== frame_bits(d, db, par, st2)) begin
                failures++; $display("FAIL rnd%0d_tx_bits got=%b exp=%b", it, samp, frame_bits(d, db, par, st2));
            end
            wait_rx(200, ok);
            checks++; if (!ok || rx_data !== data_mask(d, db)) begin
                failures++; $display("FAIL rnd%0d_rx_data got=%h exp=%h", it, rx_data, data_mask(d, db));
            end
            checks++; if ({rx_parity_err, rx_frame_err, rx_overrun} !== 3'b000) begin
                failures++; $display("FAIL rnd%0d_flags got=%b exp=000", it, {rx_parity_err, rx_frame_err, rx_overrun});
            end
            take_rx();
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
